// File: rtl/pc_exception_unit.sv
// pc_exception_unit
// Architectural PC and EPC registers for the multicycle datapath, with
// branch-condition resolution and an exception-entry sequencer. On an
// exception the sequencer saves the faulting PC, fetches a one-byte handler
// address from the vector table and loads it into PC.

module pc_exception_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter logic [31:0] VEC_OPCODE   = 32'd253,
    parameter logic [31:0] VEC_OVERFLOW = 32'd254,
    parameter logic [31:0] VEC_DIVZERO  = 32'd255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] next_pc_address,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_type,
    input  logic        alu_zero,
    input  logic        alu_gt,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div_zero,
    input  logic [7:0]  mem_data_byte,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic [31:0] exc_mem_addr,
    output logic        exc_mem_req,
    output logic        exc_busy,
    output logic [1:0]  exc_cause
);

    // Wait counter is 4 bits wide, enough for latencies 1..15.
    localparam logic [3:0] WAIT_LOAD = MEM_LATENCY[3:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_LOAD = 2'b11
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;

    logic        branch_cond;
    logic        pc_en;
    logic        exc_any;
    logic [1:0]  cause_next;
    logic [31:0] vec_next;

    // Branch condition, write-enable resolution and prioritised cause/vector.
    always_comb begin
        branch_cond = 1'b0;
        case (branch_type)
            2'b00:   branch_cond = alu_zero;
            2'b01:   branch_cond = !alu_zero;
            2'b10:   branch_cond = alu_gt;
            default: branch_cond = !alu_gt;
        endcase

        pc_en   = pc_write | (pc_write_cond & branch_cond);
        exc_any = exc_opcode | exc_overflow | exc_div_zero;

        cause_next = 2'b00;
        vec_next   = 32'd0;
        if (exc_opcode) begin
            cause_next = 2'b01;
            vec_next   = VEC_OPCODE;
        end else if (exc_overflow) begin
            cause_next = 2'b10;
            vec_next   = VEC_OVERFLOW;
        end else if (exc_div_zero) begin
            cause_next = 2'b11;
            vec_next   = VEC_DIVZERO;
        end
    end

    // Sequencer FSM with registered outputs; also owns the PC and EPC registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            wait_cnt     <= 4'd0;
            pc           <= RESET_PC;
            epc          <= 32'd0;
            exc_cause    <= 2'b00;
            exc_mem_addr <= 32'd0;
            exc_mem_req  <= 1'b0;
            exc_busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // An exception takes precedence over any PC write this cycle.
                    if (exc_any) begin
                        epc          <= pc - 32'd4;
                        exc_cause    <= cause_next;
                        exc_mem_addr <= vec_next;
                        exc_mem_req  <= 1'b1;
                        exc_busy     <= 1'b1;
                        state        <= S_REQ;
                    end else if (pc_en) begin
                        pc <= next_pc_address;
                    end
                end
                S_REQ: begin
                    exc_mem_req <= 1'b0;
                    wait_cnt    <= WAIT_LOAD;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    // A count of 0 is treated like 1 so the sequencer never stalls forever.
                    if (wait_cnt <= 4'd1) begin
                        state <= S_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_LOAD: begin
                    pc           <= {24'b0, mem_data_byte};
                    exc_mem_addr <= 32'd0;
                    exc_busy     <= 1'b0;
                    state        <= S_IDLE;
                end
                default: begin
                    exc_mem_addr <= 32'd0;
                    exc_mem_req  <= 1'b0;
                    exc_busy     <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_exception_unit.sv
// Directed testbench for pc_exception_unit (MEM_LATENCY = 1).
module tb_pc_exception_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] next_pc_address;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  branch_type;
    logic        alu_zero;
    logic        alu_gt;
    logic        exc_opcode;
    logic        exc_overflow;
    logic        exc_div_zero;
    logic [7:0]  mem_data_byte;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] exc_mem_addr;
    logic        exc_mem_req;
    logic        exc_busy;
    logic [1:0]  exc_cause;

    int total;
    int bad;

    pc_exception_unit #(
        .RESET_PC    (32'h0000_0000),
        .MEM_LATENCY (1),
        .VEC_OPCODE  (32'd253),
        .VEC_OVERFLOW(32'd254),
        .VEC_DIVZERO (32'd255)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .next_pc_address(next_pc_address),
        .pc_write       (pc_write),
        .pc_write_cond  (pc_write_cond),
        .branch_type    (branch_type),
        .alu_zero       (alu_zero),
        .alu_gt         (alu_gt),
        .exc_opcode     (exc_opcode),
        .exc_overflow   (exc_overflow),
        .exc_div_zero   (exc_div_zero),
        .mem_data_byte  (mem_data_byte),
        .pc             (pc),
        .epc            (epc),
        .exc_mem_addr   (exc_mem_addr),
        .exc_mem_req    (exc_mem_req),
        .exc_busy       (exc_busy),
        .exc_cause      (exc_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Branch vectors: type, zero, gt, cond-enable, expected taken.
    logic [1:0] bt_v  [0:8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00};
    logic       z_v   [0:8] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
    logic       g_v   [0:8] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    logic       en_v  [0:8] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0};
    logic       tk_v  [0:8] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};

    initial begin
        logic [31:0] exp_pc;
        total = 0;
        bad   = 0;

        reset_n = 1'b0;
        next_pc_address = 32'd0;
        pc_write = 1'b0;
        pc_write_cond = 1'b0;
        branch_type = 2'b00;
        alu_zero = 1'b0;
        alu_gt = 1'b0;
        exc_opcode = 1'b0;
        exc_overflow = 1'b0;
        exc_div_zero = 1'b0;
        mem_data_byte = 8'h00;

        // Reset state
        tick();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_busy", {31'b0, exc_busy}, 32'h0);
        chk("rst_cause", {30'b0, exc_cause}, 32'h0);
        chk("rst_addr", exc_mem_addr, 32'h0);
        chk("rst_req", {31'b0, exc_mem_req}, 32'h0);
        reset_n = 1'b1;
        tick();
        chk("rst_hold_pc", pc, 32'h0);

        // Unconditional write
        pc_write = 1'b1;
        next_pc_address = 32'h0000_0004;
        tick();
        pc_write = 1'b0;
        chk("uncond_pc", pc, 32'h0000_0004);
        chk("uncond_epc", epc, 32'h0);
        chk("uncond_busy", {31'b0, exc_busy}, 32'h0);
        exp_pc = 32'h0000_0004;

        // Conditional branches
        for (int i = 0; i < 9; i++) begin
            pc_write_cond   = en_v[i];
            branch_type     = bt_v[i];
            alu_zero        = z_v[i];
            alu_gt          = g_v[i];
            next_pc_address = 32'h0000_0040 + 32'(i) * 32'h10;
            tick();
            if (tk_v[i]) exp_pc = next_pc_address;
            chk($sformatf("branch%0d_pc", i), pc, exp_pc);
        end
        pc_write_cond = 1'b0;

        // Overflow exception with simultaneous pc_write
        pc_write = 1'b1;
        next_pc_address = 32'h0000_0010;
        tick();
        chk("pre_ovf_pc", pc, 32'h0000_0010);
        next_pc_address = 32'h0000_0100;
        exc_overflow = 1'b1;
        mem_data_byte = 8'h7C;
        tick();
        exc_overflow = 1'b0;
        chk("ovf_epc", epc, 32'h0000_000C);
        chk("ovf_cause", {30'b0, exc_cause}, 32'h2);
        chk("ovf_req_addr", exc_mem_addr, 32'd254);
        chk("ovf_req", {31'b0, exc_mem_req}, 32'h1);
        chk("ovf_req_busy", {31'b0, exc_busy}, 32'h1);
        chk("ovf_req_pc", pc, 32'h0000_0010);
        tick();
        chk("ovf_wait_req", {31'b0, exc_mem_req}, 32'h0);
        chk("ovf_wait_addr", exc_mem_addr, 32'd254);
        chk("ovf_wait_busy", {31'b0, exc_busy}, 32'h1);
        chk("ovf_wait_pc", pc, 32'h0000_0010);
        tick();
        chk("ovf_load_busy", {31'b0, exc_busy}, 32'h1);
        chk("ovf_load_pc", pc, 32'h0000_0010);
        tick();
        pc_write = 1'b0;
        chk("ovf_done_pc", pc, 32'h0000_007C);
        chk("ovf_done_busy", {31'b0, exc_busy}, 32'h0);
        chk("ovf_done_addr", exc_mem_addr, 32'h0);
        chk("ovf_done_epc", epc, 32'h0000_000C);
        tick();
        chk("ovf_idle_pc", pc, 32'h0000_007C);

        // Opcode beats div-zero; overflow during WAIT is dropped
        exc_opcode = 1'b1;
        exc_div_zero = 1'b1;
        mem_data_byte = 8'h20;
        tick();
        exc_opcode = 1'b0;
        exc_div_zero = 1'b0;
        chk("prio_cause", {30'b0, exc_cause}, 32'h1);
        chk("prio_addr", exc_mem_addr, 32'd253);
        chk("prio_epc", epc, 32'h0000_0078);
        tick();
        exc_overflow = 1'b1;
        tick();
        chk("drop_cause", {30'b0, exc_cause}, 32'h1);
        chk("drop_epc", epc, 32'h0000_0078);
        tick();
        exc_overflow = 1'b0;
        chk("prio_done_pc", pc, 32'h0000_0020);
        chk("prio_done_busy", {31'b0, exc_busy}, 32'h0);
        chk("prio_done_cause", {30'b0, exc_cause}, 32'h1);

        // Div-zero at pc=0 wraps epc
        pc_write = 1'b1;
        next_pc_address = 32'h0;
        tick();
        pc_write = 1'b0;
        chk("dz_pre_pc", pc, 32'h0);
        exc_div_zero = 1'b1;
        mem_data_byte = 8'h44;
        tick();
        exc_div_zero = 1'b0;
        chk("dz_epc", epc, 32'hFFFF_FFFC);
        chk("dz_addr", exc_mem_addr, 32'd255);
        chk("dz_cause", {30'b0, exc_cause}, 32'h3);
        tick();
        tick();
        tick();
        chk("dz_done_pc", pc, 32'h0000_0044);

        // Reset during WAIT
        exc_opcode = 1'b1;
        mem_data_byte = 8'h99;
        tick();
        exc_opcode = 1'b0;
        tick();
        chk("mid_wait_busy", {31'b0, exc_busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_busy", {31'b0, exc_busy}, 32'h0);
        chk("mid_rst_epc", epc, 32'h0);
        chk("mid_rst_cause", {30'b0, exc_cause}, 32'h0);
        chk("mid_rst_addr", exc_mem_addr, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        chk("post_rst_pc", pc, 32'h0);
        chk("post_rst_busy", {31'b0, exc_busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_exception_unit.md
Name: pc_exception_unit

Overview:
- Holds the architectural PC and EPC registers for the multicycle datapath.
- Sits directly downstream of the PC-source mux and consumes its next-PC output.
- Resolves the unconditional and conditional PC write enables, including branch-condition evaluation from the ALU flags.
- Owns the exception-entry sequencer: captures EPC, fetches the handler byte from the vector table in memory, and loads it into PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- MEM_LATENCY, 1, memory read latency in cycles (WAIT state length); legal range 1..15.
- VEC_OPCODE, 32'd253, vector byte address for the invalid-opcode exception.
- VEC_OVERFLOW, 32'd254, vector byte address for the arithmetic-overflow exception.
- VEC_DIVZERO, 32'd255, vector byte address for the divide-by-zero exception.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- next_pc_address  input  32  candidate next PC from the PC-source mux.
- pc_write  input  1  unconditional PC write enable from control.
- pc_write_cond  input  1  conditional (branch) PC write enable.
- branch_type  input  2  00 beq, 01 bne, 10 bgt, 11 ble.
- alu_zero  input  1  ALU zero flag.
- alu_gt  input  1  ALU greater-than flag (signed A>B).
- exc_opcode  input  1  invalid-opcode exception request.
- exc_overflow  input  1  overflow exception request.
- exc_div_zero  input  1  divide-by-zero exception request.
- mem_data_byte  input  8  low byte of the memory read data.
- pc  output  32  current PC.
- epc  output  32  exception PC.
- exc_mem_addr  output  32  vector address driven to the memory address mux.
- exc_mem_req  output  1  one-cycle memory read strobe for the vector fetch.
- exc_busy  output  1  high while the sequencer is not IDLE; control must stall.
- exc_cause  output  2  latched cause: 00 none, 01 opcode, 10 overflow, 11 div-zero.

Behaviour:
- Reset (async, reset_n=0) values:
  - pc=RESET_PC, epc=0.
  - exc_cause=00, state=IDLE.
  - exc_mem_addr=0, exc_mem_req=0, exc_busy=0.
- Branch condition: cond = beq ? alu_zero : bne ? !alu_zero : bgt ? alu_gt : !alu_gt.
- IDLE, no exception input high:
  - pc <= next_pc_address when pc_write | (pc_write_cond & cond); otherwise pc holds.
  - Write takes effect at the edge; new pc is visible the next cycle.
- IDLE, any exc_* input high at edge k:
  - pc is NOT written, even if pc_write=1 in the same cycle. Exception wins.
  - epc <= pc - 32'd4, modulo 2^32 (pc=0 gives epc=FFFF_FFFC).
  - exc_cause is latched by priority: opcode > overflow > div_zero.
  - state -> REQ.
- REQ (1 cycle):
  - exc_mem_addr = vector for the latched cause.
  - exc_mem_req=1.
  - Wait counter loaded with MEM_LATENCY.
- WAIT (MEM_LATENCY cycles):
  - exc_mem_addr held, exc_mem_req=0.
  - Counter decrements; leaves WAIT when it reaches 1.
- LOAD (1 cycle):
  - pc <= {24'b0, mem_data_byte} at the edge ending LOAD.
  - state -> IDLE.
  - exc_cause and epc hold until the next exception.
- Latency and stall behaviour:
  - exc_busy=1 in REQ, WAIT and LOAD: MEM_LATENCY+2 cycles in total.
  - While busy, pc_write, pc_write_cond and all exc_* inputs are ignored. New exceptions are dropped, not queued.
- exc_mem_addr returns to 0 in IDLE.
- Reset asserted mid-sequence: immediate return to reset values; no partial PC load.
- Unused or illegal state encodings recover to IDLE.

Test Plan:
1. Reset, then pc_write=1 with next_pc_address=0000_0004 for one cycle -> pc=0000_0004 the next cycle; epc=0; exc_busy=0.
2. pc_write_cond=1, branch_type=00, alu_zero=0, next=0000_0040 -> pc unchanged. Repeat with alu_zero=1 -> pc=0000_0040. Repeat for bne/bgt/ble with both flag values.
3. pc=0000_0010, exc_overflow=1 and pc_write=1 together, MEM_LATENCY=1, mem_data_byte=8'h7C:
   - epc=0000_000C and exc_cause=10.
   - REQ cycle has exc_mem_addr=254 and exc_mem_req=1.
   - pc=0000_007C after 3 busy cycles; pc_write ignored throughout.
4. exc_opcode and exc_div_zero asserted together -> exc_cause=01 and exc_mem_addr=253. A second exc_overflow during WAIT is ignored (cause stays 01).
5. pc=0000_0000 with exc_div_zero -> epc=FFFF_FFFC and vector address 255.
6. reset_n pulsed low during WAIT -> pc=RESET_PC, exc_busy=0 and state IDLE immediately. No load occurs after release.
